// File: rtl/seq_det_mealy.sv
// seq_det_mealy: overlapping 4-bit serial pattern detector, Mealy style.
// The state is the number of pattern bits currently matched (0..3).
// The transition table is derived from PATTERN by a prefix/suffix search,
// so changing PATTERN or OVERLAP needs no hand-edited table.
// dout is a zero-latency combinational flag: high in the cycle the final
// pattern bit is present on din while the FSM sits in S3.
module seq_det_mealy #(
  parameter logic [3:0] PATTERN = 4'b1101,
  parameter bit         OVERLAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic       dout,
  output logic [1:0] current_state
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t state_r;
  state_t next_s;
  logic   match_s;

  // Next matched length: the longest suffix of (matched prefix, bit_in) that is
  // also a proper prefix of PATTERN, capped at 3. A full match with OVERLAP=0
  // restarts from zero instead of reusing the suffix.
  function automatic logic [1:0] kmp_next(input logic [1:0] matched, input logic bit_in);
    logic [3:0] prefix_v;
    logic [3:0] cand_v;
    logic [3:0] mask_v;
    logic [3:0] target_v;
    logic [1:0] best_v;
    // Matched prefix right-aligned, then the new bit appended as the newest bit.
    prefix_v = PATTERN >> (3'd4 - {1'b0, matched});
    cand_v   = {prefix_v[2:0], bit_in};
    best_v   = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      mask_v   = (4'b0001 << k) - 4'b0001;
      target_v = PATTERN >> (4 - k);
      // Only suffixes no longer than the candidate string are meaningful.
      if ((k <= int'(matched) + 1) && ((cand_v & mask_v) == target_v)) begin
        best_v = 2'(k);
      end else begin
        best_v = best_v;
      end
    end
    if ((matched == 2'd3) && (bit_in == PATTERN[0]) && !OVERLAP) begin
      best_v = 2'd0;
    end else begin
      best_v = best_v;
    end
    return best_v;
  endfunction

  // Next-state and full-match decode from the current state and the live input bit.
  always_comb begin
    next_s  = state_t'(kmp_next(state_r, din));
    match_s = 1'b0;
    if ((state_r == S3) && (din == PATTERN[0])) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
  end

  // Mealy output: follows din immediately, forced low while reset is asserted.
  always_comb begin
    dout = 1'b0;
    if (!reset) begin
      dout = 1'b0;
    end else begin
      dout = match_s;
    end
  end

  // State register; an asynchronous reset drops any partial match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S0;
    end else begin
      state_r <= next_s;
    end
  end

  assign current_state = state_r;

endmodule

// File: tb/tb_seq_det_mealy.sv
// Bench for seq_det_mealy: three instances (default, OVERLAP=0, PATTERN=1011)
// share clk/reset/din. A history-based reference model pushes expected
// {dout, state} per driven bit into a scoreboard queue; each test task pops and
// compares inline, plus checks against hand-derived constants.
module tb_seq_det_mealy;

  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic       d0, d1, d2;
  logic [1:0] s0, s1, s2;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       d0;
    logic       d1;
    logic       d2;
    logic [1:0] s0;
    logic [1:0] s1;
    logic [1:0] s2;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state: recent bits (newest at [0]) and count since restart.
  logic [3:0] mh   [3];
  int         mn   [3];
  logic [3:0] mpat [3];
  bit         movl [3];

  always #5 clk = ~clk;

  seq_det_mealy u_def (
    .clk(clk), .reset(reset), .din(din), .dout(d0), .current_state(s0)
  );

  seq_det_mealy #(.PATTERN(4'b1101), .OVERLAP(1'b0)) u_novl (
    .clk(clk), .reset(reset), .din(din), .dout(d1), .current_state(s1)
  );

  seq_det_mealy #(.PATTERN(4'b1011), .OVERLAP(1'b1)) u_alt (
    .clk(clk), .reset(reset), .din(din), .dout(d2), .current_state(s2)
  );

  // Longest suffix of the history (since restart) that is a proper prefix of pat.
  function automatic logic [1:0] model_state(input logic [3:0] pat, input logic [3:0] h, input int n);
    logic [1:0] best;
    bit         ok;
    best = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      if (k <= n) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (h[j] !== pat[4-k+j]) ok = 1'b0;
        end
        if (ok) best = 2'(k);
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    mpat[0] = 4'b1101; movl[0] = 1'b1;
    mpat[1] = 4'b1101; movl[1] = 1'b0;
    mpat[2] = 4'b1011; movl[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mh[i] = 4'b0000;
      mn[i] = 0;
    end
  endtask

  // Drive one bit at the falling edge and push the model's expected pre-edge outputs.
  task automatic drive_bit(input logic b);
    logic [3:0] h2;
    int         n2;
    logic       dd [3];
    logic [1:0] st [3];
    exp_t       e;
    @(negedge clk);
    din = b;
    for (int i = 0; i < 3; i++) begin
      st[i] = model_state(mpat[i], mh[i], mn[i]);
      h2    = {mh[i][2:0], b};
      n2    = (mn[i] < 4) ? mn[i] + 1 : 4;
      dd[i] = (n2 >= 4) && (h2 == mpat[i]);
      if (dd[i] && !movl[i]) begin
        mh[i] = 4'b0000;
        mn[i] = 0;
      end else begin
        mh[i] = h2;
        mn[i] = n2;
      end
    end
    e.d0 = dd[0]; e.d1 = dd[1]; e.d2 = dd[2];
    e.s0 = st[0]; e.s1 = st[1]; e.s2 = st[2];
    sb_q.push_back(e);
    #1;
  endtask

  // Assert reset between edges, hold through one rising edge, release away from the edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    din   = 1'b0;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    din   = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      din = (c % 2 == 0) ? 1'b1 : 1'b0;
      #1;
      vectors++;
      if ({s0, s1, s2} !== 6'b000000 || {d0, d1, d2} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_low c%0d: state %b%b%b dout %b%b%b, need 000000/000", c, s0, s1, s2, d0, d1, d2);
      end
      @(posedge clk);
      #1;
      vectors++;
      if ({s0, s1, s2} !== 6'b000000) begin
        miscompares++;
        $display("FAIL reset_hold c%0d: state %b%b%b, need 000000", c, s0, s1, s2);
      end
    end
    din = 1'b0;
    #1 reset = 1'b1;
  endtask

  task automatic test_default_pattern();
    logic [20:0] bits;
    logic [20:0] gold;
    exp_t        e;
    do_reset();
    bits = 21'b101101001011010111011;
    gold = (21'd1 << 5) | (21'd1 << 13) | (21'd1 << 19);
    for (int i = 0; i < 21; i++) begin
      drive_bit(bits[20-i]);
      e = sb_q.pop_front();
      vectors++;
      if (d0 !== e.d0 || s0 !== e.s0) begin
        miscompares++;
        $display("FAIL default bit%0d: dout %b state %b, need %b %b", i, d0, s0, e.d0, e.s0);
      end
      vectors++;
      if (d0 !== gold[i]) begin
        miscompares++;
        $display("FAIL default_gold bit%0d: dout %b, need %b", i, d0, gold[i]);
      end
      if (i == 20) begin
        vectors++;
        if (s0 !== 2'b01) begin
          miscompares++;
          $display("FAIL default_pre20: state %b, need 01", s0);
        end
      end
    end
    @(posedge clk);
    #1;
    vectors++;
    if (s0 !== 2'b10) begin
      miscompares++;
      $display("FAIL default_post20: state %b, need 10", s0);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] bits;
    logic [6:0] gold_ov;
    logic [6:0] gold_no;
    exp_t       e;
    do_reset();
    bits    = 7'b1101101;
    gold_ov = (7'd1 << 3) | (7'd1 << 6);
    gold_no = 7'd1 << 3;
    for (int i = 0; i < 7; i++) begin
      drive_bit(bits[6-i]);
      e = sb_q.pop_front();
      vectors++;
      if (d0 !== gold_ov[i] || d0 !== e.d0 || s0 !== e.s0) begin
        miscompares++;
        $display("FAIL overlap1 bit%0d: dout %b state %b, need %b %b", i, d0, s0, gold_ov[i], e.s0);
      end
      vectors++;
      if (d1 !== gold_no[i] || d1 !== e.d1 || s1 !== e.s1) begin
        miscompares++;
        $display("FAIL overlap0 bit%0d: dout %b state %b, need %b %b", i, d1, s1, gold_no[i], e.s1);
      end
    end
  endtask

  task automatic test_self_loop();
    logic [5:0]  bits;
    logic [11:0] gold_st;
    exp_t        e;
    do_reset();
    bits    = 6'b111101;
    gold_st = 12'b00_01_10_10_10_11;
    for (int i = 0; i < 6; i++) begin
      drive_bit(bits[5-i]);
      e = sb_q.pop_front();
      vectors++;
      if (s0 !== gold_st[11-2*i -: 2] || s0 !== e.s0 || d0 !== (i == 5) || d0 !== e.d0) begin
        miscompares++;
        $display("FAIL self_loop bit%0d: state %b dout %b, need %b %b", i, s0, d0, gold_st[11-2*i -: 2], (i == 5));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] bits;
    exp_t       e;
    do_reset();
    bits = 3'b110;
    for (int i = 0; i < 3; i++) begin
      drive_bit(bits[2-i]);
      e = sb_q.pop_front();
      vectors++;
      if (s0 !== e.s0 || d0 !== e.d0) begin
        miscompares++;
        $display("FAIL async_pre bit%0d: state %b dout %b, need %b %b", i, s0, d0, e.s0, e.d0);
      end
    end
    @(negedge clk);
    din = 1'b1;
    #1;
    vectors++;
    if (s0 !== 2'b11 || d0 !== 1'b1) begin
      miscompares++;
      $display("FAIL async_s3: state %b dout %b, need 11 1", s0, d0);
    end
    #1 reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({s0, s1, s2} !== 6'b000000 || {d0, d1, d2} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_assert: state %b%b%b dout %b%b%b, need 000000/000", s0, s1, s2, d0, d1, d2);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (s0 !== 2'b00) begin
      miscompares++;
      $display("FAIL async_hold: state %b, need 00", s0);
    end
    reset = 1'b1;
    drive_bit(1'b1);
    e = sb_q.pop_front();
    vectors++;
    if (s0 !== e.s0 || d0 !== e.d0) begin
      miscompares++;
      $display("FAIL async_release: state %b dout %b, need %b %b", s0, d0, e.s0, e.d0);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (s0 !== 2'b01) begin
      miscompares++;
      $display("FAIL async_after: state %b, need 01", s0);
    end
  endtask

  task automatic test_alt_pattern();
    logic [6:0] bits;
    logic [6:0] gold;
    exp_t       e;
    do_reset();
    bits = 7'b1011011;
    gold = (7'd1 << 3) | (7'd1 << 6);
    for (int i = 0; i < 7; i++) begin
      drive_bit(bits[6-i]);
      e = sb_q.pop_front();
      vectors++;
      if (d2 !== gold[i] || d2 !== e.d2 || s2 !== e.s2) begin
        miscompares++;
        $display("FAIL alt bit%0d: dout %b state %b, need %b %b", i, d2, s2, gold[i], e.s2);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive_bit(1'($urandom_range(0, 1)));
      e = sb_q.pop_front();
      vectors++;
      if ({d0, d1, d2} !== {e.d0, e.d1, e.d2} || {s0, s1, s2} !== {e.s0, e.s1, e.s2}) begin
        miscompares++;
        $display("FAIL random bit%0d: dout %b%b%b state %b%b%b, need %b%b%b %b%b%b", i,
                 d0, d1, d2, s0, s1, s2, e.d0, e.d1, e.d2, e.s0, e.s1, e.s2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_pattern();
    test_overlap();
    test_self_loop();
    test_async_reset();
    test_alt_pattern();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
